fir_tap_sequencer: RTL and testbench



---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_tap_sequencer_if.sv | 38 +++
 rtl/fir_ring_ptr.sv | 28 ++
 rtl/fir_tap_sequencer.sv | 134 +++++++++++++
 tb/tb_fir_tap_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the FIR tap sequencer, coefficient ROM and sample RAM.
package fir_pkg;

   localparam int unsigned DEFAULT_MAX_TAPS = 64;

   // Sequencer state encoding (kept as plain constants for legacy netlists)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Tap index / ring pointer width for a given coefficient depth
   function automatic int unsigned tap_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Channel index width; a single channel still gets one bit
   function automatic int unsigned ch_width(input int unsigned channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Handshake and address bus between the sequencer, sample receiver and MAC.
interface fir_tap_sequencer_if
   import fir_pkg::*;
#(
   parameter int unsigned MAX_TAPS = DEFAULT_MAX_TAPS,
   parameter int unsigned CHANNELS = 1
) ();

   localparam int unsigned TAP_W = tap_width(MAX_TAPS);
   localparam int unsigned CH_W  = ch_width(CHANNELS);

   logic                   start;
   logic [TAP_W:0]         num_taps;
   logic                   hold;
   logic                   sample_push;
   logic [TAP_W-1:0]       wr_ptr;
   logic [TAP_W-1:0]       coeff_addr;
   logic [CH_W+TAP_W-1:0]  sample_addr;
   logic [CH_W-1:0]        channel;
   logic                   addr_valid;
   logic                   first_tap;
   logic                   last_tap;
   logic                   busy;
   logic                   done;

   modport master (
      output start, num_taps, hold, sample_push,
      input  wr_ptr, coeff_addr, sample_addr, channel, addr_valid,
             first_tap, last_tap, busy, done
   );

   modport slave (
      input  start, num_taps, hold, sample_push,
      output wr_ptr, coeff_addr, sample_addr, channel, addr_valid,
             first_tap, last_tap, busy, done
   );

endinterface

// File: rtl/fir_ring_ptr.sv
// Circular sample-RAM write pointer, wraps modulo MAX_TAPS.
module fir_ring_ptr
   import fir_pkg::*;
#(
   parameter int unsigned MAX_TAPS = DEFAULT_MAX_TAPS
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            i_inc,
   output logic [tap_width(MAX_TAPS)-1:0]  o_ptr
);

   localparam int unsigned TAP_W = tap_width(MAX_TAPS);
   localparam logic [TAP_W-1:0] ONE_T = TAP_W'(1);

   logic [TAP_W-1:0] r_ptr;

   // Advance one slot per pushed sample; power-of-two depth wraps naturally
   always_ff @(posedge clock) begin
      if (reset)
         r_ptr <= '0;
      else if (i_inc)
         r_ptr <= r_ptr + ONE_T;
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Coefficient / sample-ring address sequencer for one FIR output per channel.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int unsigned MAX_TAPS = DEFAULT_MAX_TAPS,
   parameter int unsigned CHANNELS = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   fir_tap_sequencer_if.slave   bus
);

   localparam int unsigned TAP_W = tap_width(MAX_TAPS);
   localparam int unsigned CH_W  = ch_width(CHANNELS);

   localparam logic [TAP_W:0]   MAX_N   = (TAP_W+1)'(MAX_TAPS);
   localparam logic [TAP_W:0]   ONE_N   = (TAP_W+1)'(1);
   localparam logic [TAP_W-1:0] ONE_T   = TAP_W'(1);
   localparam logic [CH_W-1:0]  ONE_C   = CH_W'(1);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);

   logic [1:0]             r_state;
   logic [TAP_W-1:0]       r_tap;
   logic [CH_W-1:0]        r_chan;
   logic [TAP_W:0]         r_neff;
   logic [TAP_W-1:0]       r_base;

   logic [TAP_W-1:0]       r_coeff;
   logic [CH_W+TAP_W-1:0]  r_saddr;
   logic [CH_W-1:0]        r_chan_o;
   logic                   r_valid;
   logic                   r_first;
   logic                   r_last;
   logic                   r_busy;
   logic                   r_done;

   logic [TAP_W-1:0]       w_wr_ptr;
   logic [TAP_W:0]         w_n_eff;
   logic [TAP_W-1:0]       w_slot;
   logic                   w_tap_last;
   logic                   w_ch_last;

   fir_ring_ptr #(.MAX_TAPS(MAX_TAPS)) u_wr_ptr (
      .clock (clock),
      .reset (reset),
      .i_inc (bus.sample_push),
      .o_ptr (w_wr_ptr)
   );

   assign w_n_eff    = (bus.num_taps > MAX_N) ? MAX_N : bus.num_taps;
   assign w_slot     = r_base - r_tap;
   assign w_tap_last = ({1'b0, r_tap} == (r_neff - ONE_N));
   assign w_ch_last  = (r_chan == LAST_CH);

   // Run control plus registered address/flag outputs. In RUN the output
   // registers always reload from the pending tap, so a held cycle shows the
   // address that will be presented on release, just with addr_valid low.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_tap    <= '0;
         r_chan   <= '0;
         r_neff   <= '0;
         r_base   <= '0;
         r_coeff  <= '0;
         r_saddr  <= '0;
         r_chan_o <= '0;
         r_valid  <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_valid <= 1'b0;
               r_first <= 1'b0;
               r_last  <= 1'b0;
               if (bus.start) begin
                  r_neff <= w_n_eff;
                  r_base <= w_wr_ptr - ONE_T;
                  r_tap  <= '0;
                  r_chan <= '0;
                  if (w_n_eff == '0) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_coeff  <= r_tap;
               r_saddr  <= {r_chan, w_slot};
               r_chan_o <= r_chan;
               r_first  <= (r_tap == '0);
               r_last   <= w_tap_last;
               r_valid  <= !bus.hold;
               if (!bus.hold) begin
                  if (!w_tap_last) begin
                     r_tap <= r_tap + ONE_T;
                  end else if (!w_ch_last) begin
                     r_tap  <= '0;
                     r_chan <= r_chan + ONE_C;
                  end else begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               r_valid <= 1'b0;
               r_first <= 1'b0;
               r_last  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wr_ptr      = w_wr_ptr;
   assign bus.coeff_addr  = r_coeff;
   assign bus.sample_addr = r_saddr;
   assign bus.channel     = r_chan_o;
   assign bus.addr_valid  = r_valid;
   assign bus.first_tap   = r_first;
   assign bus.last_tap    = r_last;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench: one single-channel and one dual-channel sequencer.
module tb_fir_tap_sequencer;
   import fir_pkg::*;

   localparam int unsigned MT = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fir_tap_sequencer_if #(.MAX_TAPS(MT), .CHANNELS(1)) bus0 ();
   fir_tap_sequencer_if #(.MAX_TAPS(MT), .CHANNELS(2)) bus1 ();

   fir_tap_sequencer #(.MAX_TAPS(MT), .CHANNELS(1)) u_dut0 (
      .clock (clock), .reset (reset), .bus (bus0));
   fir_tap_sequencer #(.MAX_TAPS(MT), .CHANNELS(2)) u_dut1 (
      .clock (clock), .reset (reset), .bus (bus1));

   typedef struct packed {
      logic [5:0] coeff;
      logic [6:0] saddr;
      logic       ch;
      logic       first;
      logic       last;
   } exp_t;

   typedef struct packed {
      logic       valid;
      logic [5:0] coeff;
      logic [6:0] saddr;
      logic       ch;
      logic       first;
      logic       last;
      logic       busy;
      logic       done;
      logic [5:0] wr;
   } obs_t;

   typedef struct {
      int d; int taps; int pre; int hold_at; int hold_len;
      int push_run; int exp_valid; int exp_done_cyc;
   } row_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t m0e, m1e;
   int   checks = 0;
   int   errors = 0;
   int   vcnt[2];
   int   dcnt[2];
   int   mdl_wr[2];
   row_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic obs_t obs(input int d);
      obs_t o;
      if (d == 0)
         o = {bus0.addr_valid, bus0.coeff_addr, bus0.sample_addr, bus0.channel,
              bus0.first_tap, bus0.last_tap, bus0.busy, bus0.done, bus0.wr_ptr};
      else
         o = {bus1.addr_valid, bus1.coeff_addr, bus1.sample_addr, bus1.channel,
              bus1.first_tap, bus1.last_tap, bus1.busy, bus1.done, bus1.wr_ptr};
      return o;
   endfunction

   task automatic set_in(input int d, input logic s, input logic [6:0] n,
                         input logic h, input logic p);
      if (d == 0) begin
         bus0.start = s; bus0.num_taps = n; bus0.hold = h; bus0.sample_push = p;
      end else begin
         bus1.start = s; bus1.num_taps = n; bus1.hold = h; bus1.sample_push = p;
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // Scoreboard monitor: every valid address must match the oldest expectation
   always @(negedge clock) begin
      if (!reset) begin
         if (bus0.addr_valid) begin
            vcnt[0]++;
            chk("d0_sb_nonempty", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
               m0e = q0.pop_front();
               chk("d0_addr", 64'({bus0.coeff_addr, bus0.sample_addr, bus0.channel,
                                   bus0.first_tap, bus0.last_tap}), 64'(m0e));
            end
         end
         if (bus1.addr_valid) begin
            vcnt[1]++;
            chk("d1_sb_nonempty", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
               m1e = q1.pop_front();
               chk("d1_addr", 64'({bus1.coeff_addr, bus1.sample_addr, bus1.channel,
                                   bus1.first_tap, bus1.last_tap}), 64'(m1e));
            end
         end
         if (bus0.done) dcnt[0]++;
         if (bus1.done) dcnt[1]++;
      end
   end

   task automatic push_exp(input int d, input int taps);
      int   n;
      int   nch;
      int   base;
      exp_t e;
      n    = (taps > int'(MT)) ? int'(MT) : taps;
      nch  = (d == 0) ? 1 : 2;
      base = (mdl_wr[d] + int'(MT) - 1) % int'(MT);
      for (int c = 0; c < nch; c++)
         for (int t = 0; t < n; t++) begin
            e.coeff = 6'(t);
            e.saddr = {1'(c), 6'((base - t + int'(MT)) % int'(MT))};
            e.ch    = 1'(c);
            e.first = (t == 0);
            e.last  = (t == n - 1);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
         end
   endtask

   task automatic run_row(input int idx, input row_t r);
      int   v0;
      int   d0;
      int   done_cyc;
      logic h;
      logic p;
      obs_t o;
      string tag;
      tag = $sformatf("row%0d", idx);
      for (int i = 0; i < r.pre; i++) begin
         set_in(r.d, 1'b0, 7'd0, 1'b0, 1'b1);
         tick();
      end
      set_in(r.d, 1'b0, 7'd0, 1'b0, 1'b0);
      mdl_wr[r.d] = (mdl_wr[r.d] + r.pre) % int'(MT);
      o = obs(r.d);
      chk({tag, "_wr_before"}, 64'(o.wr), 64'(mdl_wr[r.d]));
      push_exp(r.d, r.taps);
      v0 = vcnt[r.d];
      d0 = dcnt[r.d];
      done_cyc = -1;
      set_in(r.d, 1'b1, 7'(r.taps), 1'b0, 1'b0);
      tick();
      for (int cyc = 1; cyc <= 300; cyc++) begin
         h = (cyc >= r.hold_at + 1) && (cyc < r.hold_at + 1 + r.hold_len);
         p = (cyc >= 2) && (cyc < 2 + r.push_run);
         set_in(r.d, 1'b0, 7'(r.taps), h, p);
         tick();
         o = obs(r.d);
         if (cyc == 1)
            chk({tag, "_busy_first"}, 64'(o.busy), 64'(r.exp_valid != 0));
         if (h)
            chk({tag, "_held"}, 64'({o.valid, o.coeff}), 64'({1'b0, 6'(r.hold_at)}));
         if (dcnt[r.d] != d0) begin
            done_cyc = cyc;
            chk({tag, "_busy_at_done"}, 64'(o.busy), 64'd0);
            break;
         end
      end
      set_in(r.d, 1'b0, 7'd0, 1'b0, 1'b0);
      tick();
      mdl_wr[r.d] = (mdl_wr[r.d] + r.push_run) % int'(MT);
      o = obs(r.d);
      chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(r.exp_done_cyc));
      chk({tag, "_done_count"}, 64'(dcnt[r.d] - d0), 64'd1);
      chk({tag, "_valid_count"}, 64'(vcnt[r.d] - v0), 64'(r.exp_valid));
      chk({tag, "_sb_drained"}, 64'((r.d == 0) ? q0.size() : q1.size()), 64'd0);
      chk({tag, "_wr_after"}, 64'(o.wr), 64'(mdl_wr[r.d]));
      if (r.d == 0) q0.delete(); else q1.delete();
   endtask

   initial begin
      obs_t o;
      int   d0;
      row_t rr;
      vcnt = '{0, 0}; dcnt = '{0, 0}; mdl_wr = '{0, 0};
      //         d taps pre hat hlen push valid done_cyc
      tbl[0] = '{0, 64,  0,  0,  0,   0,   64,  65};
      tbl[1] = '{1,  4,  2,  0,  0,   0,    8,   9};
      tbl[2] = '{0,  4,  0,  2,  3,   0,    4,   8};
      tbl[3] = '{0,  0,  0,  0,  0,   0,    0,   1};
      tbl[4] = '{0, 100, 0,  0,  0,   0,   64,  65};
      tbl[5] = '{0, 16,  0,  0,  0,   5,   16,  17};
      tbl[6] = '{0,  8,  0,  0,  0,   0,    8,   9};
      tbl[7] = '{1,  3,  0,  0,  2,   0,    6,   9};

      set_in(0, 1'b0, 7'd0, 1'b0, 1'b0);
      set_in(1, 1'b0, 7'd0, 1'b0, 1'b0);
      reset = 1'b1;
      // reset wins over simultaneous start and push
      set_in(0, 1'b1, 7'd5, 1'b0, 1'b1);
      tick(); tick();
      chk("reset_d0", 64'(obs(0)), 64'd0);
      chk("reset_d1", 64'(obs(1)), 64'd0);
      set_in(0, 1'b0, 7'd0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk("idle_d0", 64'(obs(0)), 64'd0);

      for (int i = 0; i < 8; i++)
         run_row(i, tbl[i]);

      // Reset mid-run at tap 10; a start mid-run must be ignored
      push_exp(0, 64);
      d0 = dcnt[0];
      set_in(0, 1'b1, 7'd64, 1'b0, 1'b0);
      tick();
      for (int cyc = 1; cyc <= 11; cyc++) begin
         set_in(0, cyc == 5, (cyc == 5) ? 7'd3 : 7'd64, 1'b0, 1'b0);
         tick();
      end
      o = obs(0);
      chk("pre_reset_tap", 64'({o.valid, o.coeff, o.busy}), 64'({1'b1, 6'd10, 1'b1}));
      reset = 1'b1;
      tick();
      chk("midrun_reset_d0", 64'(obs(0)), 64'd0);
      chk("midrun_reset_d1_wr", 64'(obs(1).wr), 64'd0);
      q0.delete(); q1.delete();
      mdl_wr = '{0, 0};
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("no_done_after_reset", 64'(dcnt[0] - d0), 64'd0);
      chk("idle_after_reset", 64'({obs(0).valid, obs(0).busy}), 64'd0);
      rr = '{0, 12, 0, 0, 0, 0, 12, 13};
      run_row(8, rr);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule
